// File: rtl/matrix_seq_pkg.sv
// Shared types and width helpers for the matrix operand sequencer.
//   state_t : sequencer FSM states
//   tag_t   : per-issue tag {valid, i, j, k} travelling alongside the multiplier
//   addr_w  : element address width for an NxN matrix
//   idx_w   : row/column/k index width for dimension N
// Tag index fields are TAG_IW wide so one struct serves every legal N (N <= 128).
package matrix_seq_pkg;

    localparam int DOUBLE_W = 64;
    localparam int TAG_IW   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_IW-1:0] i;
        logic [TAG_IW-1:0] j;
        logic [TAG_IW-1:0] k;
    } tag_t;

    function automatic int addr_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_operand_sequencer_tag_delay.sv
// matrix_tag_delay: enable-gated DEPTH-deep shift register carrying issue tags
// so they emerge together with the multiplier's product.
//   clk, reset (async, active-low), clk_enable : clocking / freeze control
//   tag_in       : tag entering the line this enabled cycle
//   tag_out      : tag at the end of the line (aligned with the product)
//   line_pending : a valid tag sits in a stage that has not yet reached tag_out
module matrix_tag_delay
    import matrix_seq_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic line_pending
);

    tag_t line [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                line[s] <= '0;
            end
        end else if (clk_enable) begin
            line[0] <= tag_in;
            for (int s = 1; s < DEPTH; s++) begin
                line[s] <= line[s-1];
            end
        end
    end

    assign tag_out = line[DEPTH-1];

    // The output stage is excluded: a tag there is being delivered this cycle.
    always_comb begin
        line_pending = 1'b0;
        for (int s = 0; s < DEPTH - 1; s++) begin
            line_pending = line_pending | line[s].valid;
        end
    end

endmodule

// File: rtl/matrix_operand_sequencer.sv
// matrix_operand_sequencer: stores NxN double matrices A and B, walks (i,j,k)
// and issues A[i][k] / B[k][j] to an external multiplier, one pair per enabled
// cycle, with a tag line that labels each returning product.
// Ports:
//   clk, reset (async, active-low), clk_enable (freezes all state when low)
//   load_valid/load_sel/load_addr/load_data : element write (IDLE only)
//   start : begin a run (sampled in IDLE); busy : ISSUE..DONE; done : 1-cycle pulse
//   mul_in1/mul_in2 : registered operands to the multiplier; mul_out : product
//   prod_valid/prod_data/prod_row/prod_col/prod_k/prod_last_k : tagged product
//   ce_out : copy of clk_enable for the multiplier
// Optional build macro: MATRIX_SEQ_TRANSPOSE_B_EN -- B is held transposed, so the
// second operand is read as B[j][k] instead of B[k][j].
module matrix_operand_sequencer
    import matrix_seq_pkg::*;
#(
    parameter  int N           = 2,
    parameter  int DW          = DOUBLE_W,
    parameter  int MUL_LATENCY = 6,
    localparam int AW          = addr_w(N),
    localparam int IW          = idx_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    input  logic          load_valid,
    input  logic          load_sel,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] mul_in1,
    output logic [DW-1:0] mul_in2,
    input  logic [DW-1:0] mul_out,
    output logic          prod_valid,
    output logic [DW-1:0] prod_data,
    output logic [IW-1:0] prod_row,
    output logic [IW-1:0] prod_col,
    output logic [IW-1:0] prod_k,
    output logic          prod_last_k,
    output logic          ce_out
);

    state_t        state, state_nx;
    logic [IW-1:0] i_cnt, j_cnt, k_cnt;
    logic [DW-1:0] mem_a [N*N];
    logic [DW-1:0] mem_b [N*N];
    logic [AW-1:0] a_idx, b_idx;
    logic          last_issue;
    logic          write_en;
    logic          line_pending;
    tag_t          issue_tag;
    tag_t          tag_out;
    logic          unused_tag_bits;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    assign last_issue = (i_cnt == LAST_IDX) && (j_cnt == LAST_IDX) && (k_cnt == LAST_IDX);
    assign a_idx      = AW'(int'(i_cnt) * N + int'(k_cnt));
`ifdef MATRIX_SEQ_TRANSPOSE_B_EN
    assign b_idx      = AW'(int'(j_cnt) * N + int'(k_cnt));
`else
    assign b_idx      = AW'(int'(k_cnt) * N + int'(j_cnt));
`endif

    // Writes land on the same edge that moves IDLE->ISSUE, so an element loaded
    // together with start is already visible to the first issue read.
    assign write_en = clk_enable && load_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (write_en) begin
            if (load_sel) begin
                mem_b[load_addr] <= load_data;
            end else begin
                mem_a[load_addr] <= load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            issue_tag <= '0;
        end else if (clk_enable) begin
            state <= state_nx;
            if (state == ISSUE) begin
                mul_in1   <= mem_a[a_idx];
                mul_in2   <= mem_b[b_idx];
                issue_tag <= '{valid: 1'b1, i: TAG_IW'(i_cnt), j: TAG_IW'(j_cnt), k: TAG_IW'(k_cnt)};
                if (k_cnt == LAST_IDX) begin
                    k_cnt <= '0;
                    if (j_cnt == LAST_IDX) begin
                        j_cnt <= '0;
                        i_cnt <= (i_cnt == LAST_IDX) ? '0 : i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end else begin
                    k_cnt <= k_cnt + 1'b1;
                end
            end else begin
                issue_tag <= '0;
            end
        end
    end

    // issue_tag sits level with mul_in1/2; the delay line adds MUL_LATENCY more
    // enabled cycles so the tag meets the product on mul_out.
    matrix_tag_delay #(
        .DEPTH(MUL_LATENCY)
    ) u_tag_delay (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .tag_in       (issue_tag),
        .tag_out      (tag_out),
        .line_pending (line_pending)
    );

    // DRAIN ends once no tag remains behind the one currently being delivered.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (last_issue) state_nx = DRAIN;
            DRAIN:   if (!issue_tag.valid && !line_pending) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign prod_valid  = tag_out.valid;
    assign prod_data   = mul_out;
    assign prod_row    = tag_out.i[IW-1:0];
    assign prod_col    = tag_out.j[IW-1:0];
    assign prod_k      = tag_out.k[IW-1:0];
    assign prod_last_k = (tag_out.k == TAG_IW'(N - 1));
    assign ce_out      = clk_enable;

    assign unused_tag_bits = ^{tag_out.i[TAG_IW-1:IW], tag_out.j[TAG_IW-1:IW]};

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
module tb_matrix_operand_sequencer;

    localparam int N   = 2;
    localparam int DW  = 64;
    localparam int LAT = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          load_valid;
    logic          load_sel;
    logic [1:0]    load_addr;
    logic [DW-1:0] load_data;
    logic          start;
    logic          busy, done;
    logic [DW-1:0] mul_in1, mul_in2, mul_out;
    logic          prod_valid;
    logic [DW-1:0] prod_data;
    logic [0:0]    prod_row, prod_col, prod_k;
    logic          prod_last_k;
    logic          ce_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] d;
        int          i;
        int          j;
        int          k;
    } exp_t;
    exp_t exp_q[$];

    real am [4];
    real bm [4];

    always #5 clk = ~clk;

    matrix_operand_sequencer #(.N(N), .DW(DW), .MUL_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .load_valid(load_valid), .load_sel(load_sel), .load_addr(load_addr),
        .load_data(load_data), .start(start), .busy(busy), .done(done),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
        .prod_valid(prod_valid), .prod_data(prod_data), .prod_row(prod_row),
        .prod_col(prod_col), .prod_k(prod_k), .prod_last_k(prod_last_k),
        .ce_out(ce_out)
    );

    // Stub multiplier: 6 enabled stages of exact double multiply.
    logic [63:0] mpipe [LAT];
    always @(posedge clk) begin
        if (clk_enable) begin
            mpipe[0] <= $realtobits($bitstoreal(mul_in1) * $bitstoreal(mul_in2));
            for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
        end
    end
    assign mul_out = mpipe[LAT-1];

    task automatic push_expected();
        exp_t e;
        int   bi;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++) begin
`ifdef MATRIX_SEQ_TRANSPOSE_B_EN
                    bi = j * N + k;
`else
                    bi = k * N + j;
`endif
                    e.d = $realtobits(am[i*N+k] * bm[bi]);
                    e.i = i; e.j = j; e.k = k;
                    exp_q.push_back(e);
                end
    endtask

    task automatic load_mats();
        for (int s = 0; s < 2; s++)
            for (int idx = 0; idx < 4; idx++) begin
                @(negedge clk);
                load_valid = 1'b1;
                load_sel   = s[0];
                load_addr  = 2'(idx);
                load_data  = (s == 0) ? $realtobits(am[idx]) : $realtobits(bm[idx]);
            end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (prod_valid !== 1'b0) begin fails++; $display("FAIL reset_prod_valid got %b want 0", prod_valid); end
        tests++; if (mul_in1 !== 64'h0 || mul_in2 !== 64'h0) begin
            fails++; $display("FAIL reset_mul_in got %h/%h want 0/0", mul_in1, mul_in2);
        end
        tests++; if ({prod_row, prod_col, prod_k} !== 3'b000) begin
            fails++; $display("FAIL reset_tags got %b want 000", {prod_row, prod_col, prod_k});
        end
        tests++; if (ce_out !== 1'b1) begin fails++; $display("FAIL ce_out got %b want 1", ce_out); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One complete run with optional stall, ignored mid-run load/start, or a
    // load presented together with start.
    task automatic test_run(input string name, input int stall_at, input int stall_len,
                            input bit poke, input bit load_at_start, input bit chk_const);
        int   cyc = 0, first_valid = -1, done_cyc = -1, got = 0;
        bit   en_applied = 1'b1;
        logic [63:0] snap1 = '0, snap2 = '0, exp2;
        exp_t e;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        if (load_at_start) begin
            load_valid = 1'b1; load_sel = 1'b0; load_addr = 2'd0;
            am[0] = 2.5;
            load_data = $realtobits(am[0]);
        end
        push_expected();
        @(negedge clk);
        start = 1'b0; load_valid = 1'b0;
        while (done_cyc < 0 && cyc < 80) begin
            if (en_applied && prod_valid) begin
                if (first_valid < 0) first_valid = cyc;
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL %s extra_product at cycle %0d data %h", name, cyc, prod_data);
                end else begin
                    e = exp_q.pop_front();
                    if (prod_data !== e.d) begin
                        fails++; $display("FAIL %s prod_data got %h want %h", name, prod_data, e.d);
                    end
                    tests++;
                    if (int'(prod_row) !== e.i || int'(prod_col) !== e.j || int'(prod_k) !== e.k
                        || prod_last_k !== (e.k == N - 1)) begin
                        fails++;
                        $display("FAIL %s tag got (%0d,%0d,%0d,last %b) want (%0d,%0d,%0d)",
                                 name, prod_row, prod_col, prod_k, prod_last_k, e.i, e.j, e.k);
                    end
                end
            end
            if (!en_applied) begin
                tests++;
                if (mul_in1 !== snap1 || mul_in2 !== snap2 || busy !== 1'b1) begin
                    fails++; $display("FAIL %s stall_frozen got %h/%h busy %b want %h/%h busy 1",
                                      name, mul_in1, mul_in2, busy, snap1, snap2);
                end
            end
            if (chk_const && cyc == 1) begin
                tests++;
                if (mul_in1 !== 64'h3FF0000000000000 || mul_in2 !== 64'h4014000000000000) begin
                    fails++; $display("FAIL %s first_pair got %h/%h want 3ff0000000000000/4014000000000000",
                                      name, mul_in1, mul_in2);
                end
            end
            if (chk_const && cyc == 2) begin
`ifdef MATRIX_SEQ_TRANSPOSE_B_EN
                exp2 = 64'h4018000000000000;
`else
                exp2 = 64'h401C000000000000;
`endif
                tests++;
                if (mul_in1 !== 64'h4000000000000000 || mul_in2 !== exp2) begin
                    fails++; $display("FAIL %s pair_001 got %h/%h want 4000000000000000/%h",
                                      name, mul_in1, mul_in2, exp2);
                end
            end
            if (done) done_cyc = cyc;
            // drive inputs for the next rising edge
            clk_enable = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
            en_applied = clk_enable;
            snap1 = mul_in1; snap2 = mul_in2;
            start      = poke && (cyc == 4);
            load_valid = poke && (cyc == 4);
            load_sel   = 1'b0;
            load_addr  = 2'd0;
            load_data  = 64'h4022000000000000;
            cyc++;
            @(negedge clk);
        end
        clk_enable = 1'b1; start = 1'b0; load_valid = 1'b0;
        tests++;
        if (done_cyc != 15 + stall_len) begin
            fails++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, 15 + stall_len);
        end
        tests++;
        if (first_valid != 7 + ((stall_at < 7) ? stall_len : 0)) begin
            fails++; $display("FAIL %s first_valid_cycle got %0d want %0d", name, first_valid,
                              7 + ((stall_at < 7) ? stall_len : 0));
        end
        tests++;
        if (got != N * N * N || exp_q.size() != 0) begin
            fails++; $display("FAIL %s product_count got %0d want %0d", name, got, N * N * N);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL %s idle_after_run got busy %b done %b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_abort();
        int bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || prod_valid !== 1'b0 || mul_in1 !== 64'h0 || mul_in2 !== 64'h0) begin
            fails++; $display("FAIL abort_outputs got busy %b done %b pv %b in %h/%h want all 0",
                              busy, done, prod_valid, mul_in1, mul_in2);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (prod_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL abort_quiet got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        clk_enable = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_addr = '0;
        load_data = '0; start = 1'b0;
        am = '{1.0, 2.0, 3.0, 4.0};
        bm = '{5.0, 6.0, 7.0, 8.0};
        test_reset();
        load_mats();
        test_run("basic", 99, 0, 1'b0, 1'b0, 1'b1);
        test_run("stall", 2, 3, 1'b0, 1'b0, 1'b0);
        test_abort();
        test_run("after_abort", 99, 0, 1'b0, 1'b0, 1'b1);
        test_run("busy_ignore", 99, 0, 1'b1, 1'b0, 1'b0);
        test_run("after_ignore", 99, 0, 1'b0, 1'b0, 1'b1);
        test_run("load_with_start", 99, 0, 1'b0, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
